// File: rtl/rdm_pkg.sv
// Shared types, default sizes and the layer-to-step decode for the RDM input
// address generator.
package rdm_pkg;

  localparam int RDM_NUM_USERS = 8;
  localparam int RDM_ADDR_W    = 14;
  localparam int RDM_LANE_W    = 4;
  localparam int RDM_DATA_W    = 96;
  localparam int RDM_CB_W      = 8;
  localparam int RDM_IDX_W     = 4;

  typedef enum logic [1:0] {
    USR_IDLE   = 2'd0,
    USR_ACTIVE = 2'd1,
    USR_DONE   = 2'd2
  } user_state_e;

  // Each MIMO layer contributes one lane per strobe, so the step is 1..4 lanes.
  function automatic logic [2:0] step_decode(input logic [1:0] layer_num);
    return {1'b0, layer_num} + 3'd1;
  endfunction

endpackage

// File: rtl/rdm_user_addr_ch.sv
// One user's address channel: lane offset within the current CB, CB counter,
// ping-pong bank bit and ACTIVE/DONE state.
module rdm_user_addr_ch
  import rdm_pkg::*;
#(
  parameter int ADDR_W = RDM_ADDR_W,
  parameter int CB_W   = RDM_CB_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slot_start,
  input  logic [ADDR_W-1:0] buf_start,
  input  logic [ADDR_W-1:0] e_sz,
  input  logic [CB_W-1:0]   cb_num,
  input  logic              hit,
  input  logic [2:0]        step,
  output logic [ADDR_W-1:0] lane_addr,
  output logic              active,
  output logic              pp,
  output logic              user_done,
  output logic              cb_end
);

  user_state_e       state_q, state_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] e_sz_q, e_sz_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic [CB_W-1:0]   cb_num_q, cb_num_d;
  logic [CB_W-1:0]   cnt_q, cnt_d;
  logic              pp_q, pp_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   next_off;

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    e_sz_d   = e_sz_q;
    offset_d = offset_q;
    cb_num_d = cb_num_q;
    cnt_d    = cnt_q;
    pp_d     = pp_q;
    done_d   = done_q;
    // One extra bit so offset+step never wraps before the CB-end compare.
    next_off = {1'b0, offset_q} + (ADDR_W+1)'(step);
    cb_end   = hit && (next_off >= {1'b0, e_sz_q});

    if (slot_start) begin
      start_d  = buf_start;
      e_sz_d   = e_sz;
      cb_num_d = cb_num;
      offset_d = '0;
      cnt_d    = '0;
      pp_d     = 1'b0;
      done_d   = 1'b0;
      state_d  = (cb_num != '0 && e_sz != '0) ? USR_ACTIVE : USR_DONE;
    end else if (hit) begin
      if (cb_end) begin
        offset_d = '0;
        pp_d     = !pp_q;
        cnt_d    = cnt_q + CB_W'(1);
        if (cnt_d == cb_num_q) begin
          state_d = USR_DONE;
          done_d  = 1'b1;
        end
      end else begin
        offset_d = next_off[ADDR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= USR_DONE;
      start_q  <= '0;
      e_sz_q   <= '0;
      offset_q <= '0;
      cb_num_q <= '0;
      cnt_q    <= '0;
      pp_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      e_sz_q   <= e_sz_d;
      offset_q <= offset_d;
      cb_num_q <= cb_num_d;
      cnt_q    <= cnt_d;
      pp_q     <= pp_d;
      done_q   <= done_d;
    end
  end

  assign lane_addr = start_q + offset_q;
  assign active    = (state_q == USR_ACTIVE);
  assign pp        = pp_q;
  assign user_done = done_q;

endmodule

// File: rtl/rdm_input_addr_gen.sv
// Turns demux strobes into input-buffer writes: decodes the target user, muxes
// its lane address and registers the write, CB-done and error outputs.
module rdm_input_addr_gen
  import rdm_pkg::*;
#(
  parameter int NUM_USERS = RDM_NUM_USERS,
  parameter int ADDR_W    = RDM_ADDR_W,
  parameter int LANE_W    = RDM_LANE_W,
  parameter int DATA_W    = RDM_DATA_W
) (
  input  logic                        i_core_clk,
  input  logic                        i_rx_rst,
  input  logic                        i_rdm_slot_start,
  input  logic [NUM_USERS*ADDR_W-1:0] i_users_buf_start,
  input  logic [NUM_USERS*ADDR_W-1:0] i_users_e_sz,
  input  logic [NUM_USERS*8-1:0]      i_users_cb_num,
  input  logic [1:0]                  i_layer_num,
  input  logic                        i_demux_strb,
  input  logic [3:0]                  i_demux_user_idx,
  input  logic [DATA_W-1:0]           i_demux_rx,
  output logic                        o_wr_en,
  output logic [ADDR_W-LANE_W:0]      o_wr_addr,
  output logic [LANE_W-1:0]           o_wr_lane,
  output logic [DATA_W-1:0]           o_wr_data,
  output logic                        o_cb_done,
  output logic [3:0]                  o_cb_user,
  output logic [NUM_USERS-1:0]        o_pingpong,
  output logic [NUM_USERS-1:0]        o_user_done,
  output logic                        o_err
);

  logic [NUM_USERS-1:0] hit_vec, active_vec, pp_vec, cb_end_vec, done_vec;
  logic [ADDR_W-1:0]    lane_addr_arr [NUM_USERS];
  logic [2:0]           step;
  logic                 sel_active, sel_pp, accept;
  logic [ADDR_W-1:0]    sel_addr;

  logic                 wr_en_q, wr_en_d;
  logic [ADDR_W-LANE_W:0] wr_addr_q, wr_addr_d;
  logic [LANE_W-1:0]    wr_lane_q, wr_lane_d;
  logic [DATA_W-1:0]    wr_data_q, wr_data_d;
  logic                 cb_done_q, cb_done_d;
  logic [3:0]           cb_user_q, cb_user_d;
  logic                 err_q, err_d;

  // Out-of-range indices never match a channel, so they look like DONE users.
  always_comb begin
    step       = step_decode(i_layer_num);
    sel_active = 1'b0;
    sel_pp     = 1'b0;
    sel_addr   = '0;
    for (int u = 0; u < NUM_USERS; u++) begin
      if (int'(i_demux_user_idx) == u) begin
        sel_active = active_vec[u];
        sel_pp     = pp_vec[u];
        sel_addr   = lane_addr_arr[u];
      end
    end
    accept = i_demux_strb && !i_rdm_slot_start && sel_active;
    for (int u = 0; u < NUM_USERS; u++) begin
      hit_vec[u] = accept && (int'(i_demux_user_idx) == u);
    end
  end

  for (genvar g = 0; g < NUM_USERS; g++) begin : g_user
    rdm_user_addr_ch #(
      .ADDR_W (ADDR_W),
      .CB_W   (RDM_CB_W)
    ) u_ch (
      .clk        (i_core_clk),
      .rst        (i_rx_rst),
      .slot_start (i_rdm_slot_start),
      .buf_start  (i_users_buf_start[g*ADDR_W +: ADDR_W]),
      .e_sz       (i_users_e_sz[g*ADDR_W +: ADDR_W]),
      .cb_num     (i_users_cb_num[g*8 +: 8]),
      .hit        (hit_vec[g]),
      .step       (step),
      .lane_addr  (lane_addr_arr[g]),
      .active     (active_vec[g]),
      .pp         (pp_vec[g]),
      .user_done  (done_vec[g]),
      .cb_end     (cb_end_vec[g])
    );
  end

  // The write uses the bank bit from before any toggle caused by this strobe.
  always_comb begin
    wr_en_d   = accept;
    wr_addr_d = {sel_pp, sel_addr[ADDR_W-1:LANE_W]};
    wr_lane_d = sel_addr[LANE_W-1:0];
    wr_data_d = i_demux_rx;
    cb_done_d = |cb_end_vec;
    cb_user_d = i_demux_user_idx;
    err_d     = err_q;
    if (i_rdm_slot_start) begin
      err_d = 1'b0;
    end else if (i_demux_strb && !sel_active) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_lane_q <= '0;
      wr_data_q <= '0;
      cb_done_q <= 1'b0;
      cb_user_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_lane_q <= wr_lane_d;
      wr_data_q <= wr_data_d;
      cb_done_q <= cb_done_d;
      cb_user_q <= cb_user_d;
      err_q     <= err_d;
    end
  end

  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_lane   = wr_lane_q;
  assign o_wr_data   = wr_data_q;
  assign o_cb_done   = cb_done_q;
  assign o_cb_user   = cb_user_q;
  assign o_err       = err_q;
  assign o_pingpong  = pp_vec;
  assign o_user_done = done_vec;

endmodule
